// File: rtl/i2s_pkg.sv
// Shared types and constants for the I2S receive path.
package i2s_pkg;

  typedef enum logic [1:0] {
    SYNC  = 2'd0,
    LEFT  = 2'd1,
    RIGHT = 2'd2
  } i2s_rx_state_t;

  localparam int FRAME_BITS           = 64;
  localparam int DEFAULT_SAMPLE_WIDTH = 24;
  localparam int DEFAULT_SLOT_WIDTH   = 32;
  localparam int SYNC_STAGES          = 2;

endpackage

// File: rtl/i2s_sync_edge.sv
// Multi-stage synchronizer for one edge-detected clock plus DATA_WIDTH plain data bits.
// The output stage keeps data aligned with the rise strobe it accompanies.
module i2s_sync_edge
  import i2s_pkg::*;
#(
  parameter int DATA_WIDTH = 2
) (
  input  logic                  input_clk,
  input  logic                  reset,
  input  logic                  clk_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  clk_rise,
  output logic [DATA_WIDTH-1:0] data_out
);

  localparam int W = DATA_WIDTH + 1;

  logic [W-1:0] stages [SYNC_STAGES];
  logic [W-1:0] aligned;

  always_ff @(posedge input_clk) begin
    if (!reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) stages[i] <= '0;
      aligned  <= '0;
      clk_rise <= 1'b0;
    end else begin
      stages[0] <= {data_in, clk_in};
      for (int i = 1; i < SYNC_STAGES; i++) stages[i] <= stages[i-1];
      aligned  <= stages[SYNC_STAGES-1];
      clk_rise <= stages[SYNC_STAGES-1][0] & ~aligned[0];
    end
  end

  assign data_out = aligned[W-1:1];

endmodule

// File: rtl/i2s_rx.sv
// I2S receiver: oversampled deserializer emitting stereo pairs on a valid/ready port.
// Define I2S_RX_DEBUG_EN to expose the slot bit index (bit_counter) and FSM state.
module i2s_rx
  import i2s_pkg::*;
#(
  parameter int SAMPLE_WIDTH = DEFAULT_SAMPLE_WIDTH,
  parameter int SLOT_WIDTH   = DEFAULT_SLOT_WIDTH
) (
  input  logic                    input_clk,
  input  logic                    reset,
  input  logic                    serial_clk,
  input  logic                    word_select,
  input  logic                    sound_bit_in,
  output logic [SAMPLE_WIDTH-1:0] sample_left,
  output logic [SAMPLE_WIDTH-1:0] sample_right,
  output logic                    sample_valid,
  input  logic                    sample_ready,
  output logic                    overrun,
  output logic                    frame_error
`ifdef I2S_RX_DEBUG_EN
  ,
  output logic [5:0]              bit_counter,
  output logic [1:0]              fsm_state
`endif
);

  // Handshake: a pair transfers on every cycle where sample_valid & sample_ready;
  // data is held stable while sample_valid is high and not yet accepted.

  localparam logic [5:0] IDX_MAX  = 6'(SLOT_WIDTH - 1);
  localparam logic [5:0] IDX_LSB  = 6'(SAMPLE_WIDTH - 1);
  localparam logic [5:0] IDX_FULL = 6'(SAMPLE_WIDTH);

  logic                    sck_rise;
  logic [1:0]              sync_data;
  logic                    ws;
  logic                    sd;
  logic                    ws_prev;
  logic                    ws_change;
  logic                    accept;
  logic [5:0]              idx;
  logic [SAMPLE_WIDTH-1:0] shift;
  logic [SAMPLE_WIDTH-1:0] word_next;
  logic [SAMPLE_WIDTH-1:0] left_stage;
  i2s_rx_state_t           state;

  i2s_sync_edge #(.DATA_WIDTH(2)) u_sync (
    .input_clk (input_clk),
    .reset     (reset),
    .clk_in    (serial_clk),
    .data_in   ({sound_bit_in, word_select}),
    .clk_rise  (sck_rise),
    .data_out  (sync_data)
  );

  assign ws        = sync_data[0];
  assign sd        = sync_data[1];
  assign ws_change = sck_rise & (ws != ws_prev);
  assign accept    = sample_valid & sample_ready;
  assign word_next = {shift[SAMPLE_WIDTH-2:0], sd};

  always_ff @(posedge input_clk) begin
    if (!reset) begin
      state        <= SYNC;
      ws_prev      <= 1'b0;
      idx          <= '0;
      shift        <= '0;
      left_stage   <= '0;
      sample_left  <= '0;
      sample_right <= '0;
      sample_valid <= 1'b0;
      overrun      <= 1'b0;
      frame_error  <= 1'b0;
    end else begin
      overrun     <= 1'b0;
      frame_error <= 1'b0;
      if (accept) sample_valid <= 1'b0;
      if (sck_rise) begin
        ws_prev <= ws;
        if (ws_change) begin
          // The bit riding on the WS-change strobe belongs to the old slot.
          idx <= '0;
          case (state)
            SYNC:  if (!ws) state <= LEFT;
            LEFT: begin
              if (idx < IDX_FULL) begin
                frame_error <= 1'b1;
                state       <= SYNC;
              end else begin
                state <= RIGHT;
              end
            end
            RIGHT: begin
              if (idx < IDX_FULL) frame_error <= 1'b1;
              state <= LEFT;
            end
            default: state <= SYNC;
          endcase
        end else begin
          if (idx < IDX_FULL) shift <= word_next;
          if (idx < IDX_MAX) idx <= idx + 6'd1;
          if (idx == IDX_LSB && state == LEFT) left_stage <= word_next;
          if (idx == IDX_LSB && state == RIGHT) begin
            // A same-cycle accept frees the holding register for the new pair.
            if (!sample_valid || accept) begin
              sample_left  <= left_stage;
              sample_right <= word_next;
              sample_valid <= 1'b1;
            end else begin
              overrun <= 1'b1;
            end
          end
        end
      end
    end
  end

`ifdef I2S_RX_DEBUG_EN
  assign bit_counter = idx;
  assign fsm_state   = state;
`endif

endmodule

// File: tb/tb_i2s_rx.sv
// Scoreboard bench for i2s_rx: directed I2S frames driven at input_clk/4.
module tb_i2s_rx;
  import i2s_pkg::*;

  localparam int SW = DEFAULT_SAMPLE_WIDTH;

  logic          input_clk;
  logic          reset;
  logic          serial_clk;
  logic          word_select;
  logic          sound_bit_in;
  logic [SW-1:0] sample_left;
  logic [SW-1:0] sample_right;
  logic          sample_valid;
  logic          sample_ready;
  logic          overrun;
  logic          frame_error;
`ifdef I2S_RX_DEBUG_EN
  logic [5:0]    bit_counter;
  logic [1:0]    fsm_state;
`endif

  i2s_rx dut (
    .input_clk    (input_clk),
    .reset        (reset),
    .serial_clk   (serial_clk),
    .word_select  (word_select),
    .sound_bit_in (sound_bit_in),
    .sample_left  (sample_left),
    .sample_right (sample_right),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .overrun      (overrun),
    .frame_error  (frame_error)
`ifdef I2S_RX_DEBUG_EN
    ,
    .bit_counter  (bit_counter),
    .fsm_state    (fsm_state)
`endif
  );

  // ---------------- clock / reset ----------------
  initial input_clk = 1'b0;
  always #5 input_clk = ~input_clk;

  int cyc = 0;
  always @(posedge input_clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: run did not complete within time limit");
    $fatal(1);
  end

  // ---------------- scoreboard ----------------
  logic [2*SW-1:0] exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;
  int ovr_seen = 0;
  int ferr_seen = 0;
  int rise_cycle = 0;
  int lsb_cycle = 0;
  bit lat_en = 0;
  logic valid_d = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge input_clk) begin
    logic [2*SW-1:0] e;
    if (overrun) ovr_seen++;
    if (frame_error) ferr_seen++;
    if (lat_en && sample_valid && !valid_d) begin
      check("valid_latency", 32'(cyc - lsb_cycle), 32'd4);
      lat_en = 0;
    end
    if (sample_valid && sample_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_pair: got L=0x%0h R=0x%0h expected none", sample_left, sample_right);
      end else begin
        e = exp_q.pop_front();
        check("pair_left", 32'(sample_left), 32'(e[2*SW-1:SW]));
        check("pair_right", 32'(sample_right), 32'(e[SW-1:0]));
      end
    end
    valid_d = sample_valid;
  end

  // ---------------- driver tasks ----------------
  // One bit period: 2 input_clk cycles low (data set), 2 cycles high.
  task automatic send_bit(input logic ws, input logic sd);
    serial_clk   = 1'b0;
    word_select  = ws;
    sound_bit_in = sd;
    repeat (2) @(posedge input_clk);
    #1;
    serial_clk = 1'b1;
    rise_cycle = cyc;
    repeat (2) @(posedge input_clk);
    #1;
  endtask

  task automatic send_data(input logic ws, input logic [SW-1:0] word, input int first,
                           input int last, input int npad, input logic junk);
    for (int i = first; i < last; i++) begin
      send_bit(ws, word[SW-1-i]);
      if (ws && i == SW - 1) lsb_cycle = rise_cycle;
    end
    repeat (npad) send_bit(ws, junk);
  endtask

  task automatic send_slot(input logic ws, input logic [SW-1:0] word, input logic junk);
    send_bit(ws, junk);
    send_data(ws, word, 0, SW, 7, junk);
  endtask

  task automatic send_frame(input logic [SW-1:0] l, input logic [SW-1:0] r,
                            input logic junk, input bit expect_pair);
    if (expect_pair) exp_q.push_back({l, r});
    send_slot(1'b0, l, junk);
    send_slot(1'b1, r, junk);
  endtask

  task automatic settle();
    repeat (3) @(posedge input_clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_left"}, 32'(sample_left), 32'd0);
    check({tag, "_right"}, 32'(sample_right), 32'd0);
    check({tag, "_valid"}, 32'(sample_valid), 32'd0);
    check({tag, "_overrun"}, 32'(overrun), 32'd0);
    check({tag, "_frame_error"}, 32'(frame_error), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int waited;
    reset        = 1'b0;
    serial_clk   = 1'b0;
    word_select  = 1'b0;
    sound_bit_in = 1'b0;
    sample_ready = 1'b1;
    repeat (3) @(posedge input_clk);
    @(negedge input_clk);
    check_reset_outputs("reset");
    @(posedge input_clk);
    #1;
    reset = 1'b1;

    // WS high first so the following fall enters the left slot.
    repeat (3) send_bit(1'b1, 1'b0);

    // Nominal frame, with pin-to-valid latency
    lat_en = 1;
    send_frame(24'h123456, 24'hABCDEF, 1'b0, 1);

    // Sign / MSB alignment; junk=1 on WS-change and padding bits
    send_frame(24'h800000, 24'h7FFFFF, 1'b1, 1);

    // Backpressure: A held, B dropped with one overrun, C after release
    sample_ready = 1'b0;
    send_frame(24'h0F0F0F, 24'h00FF00, 1'b0, 1);
    send_frame(24'h111111, 24'h222222, 1'b1, 0);
    check("hold_left", 32'(sample_left), 32'h0F0F0F);
    check("hold_right", 32'(sample_right), 32'h00FF00);
    check("hold_valid", 32'(sample_valid), 32'd1);
    check("overrun_count", 32'(ovr_seen), 32'd1);
    sample_ready = 1'b1;
    waited = 0;
    while (exp_q.size() != 0 && waited < 20) begin
      @(posedge input_clk);
      waited++;
    end
    #1;
    check("release_drained", 32'(exp_q.size()), 32'd0);
    send_frame(24'h5A5A5A, 24'hA5A5A5, 1'b0, 1);

    // Short left slot: 10 bits then WS rises
    send_bit(1'b0, 1'b1);
    send_data(1'b0, 24'hFFFFFF, 0, 10, 0, 1'b0);
    send_bit(1'b1, 1'b0);
    settle();
    check("short_state", 32'(dut.state), 32'(SYNC));
    check("short_frame_error", 32'(ferr_seen), 32'd1);
    send_data(1'b1, 24'h333333, 0, SW, 7, 1'b0);
    send_frame(24'hC0FFEE, 24'h0BADF0, 1'b0, 1);

    // Reset at right-slot bit 12
    send_slot(1'b0, 24'h13579B, 1'b0);
    send_bit(1'b1, 1'b0);
    send_data(1'b1, 24'h2468AC, 0, 12, 0, 1'b0);
    reset = 1'b0;
    @(posedge input_clk);
    @(negedge input_clk);
    check_reset_outputs("midreset");
    @(posedge input_clk);
    #1;
    reset = 1'b1;
    repeat (3) send_bit(1'b1, 1'b0);
    send_frame(24'h765432, 24'hFEDCBA, 1'b0, 1);

`ifdef I2S_RX_DEBUG_EN
    // 40-strobe left slot: index saturates, then clears on WS change
    exp_q.push_back({24'h2468AC, 24'h13579B});
    send_bit(1'b0, 1'b0);
    send_data(1'b0, 24'h2468AC, 0, SW, 15, 1'b1);
    settle();
    check("dbg_saturate", 32'(bit_counter), 32'd31);
    send_bit(1'b1, 1'b0);
    settle();
    check("dbg_clear", 32'(bit_counter), 32'd0);
    send_data(1'b1, 24'h13579B, 0, 5, 0, 1'b0);
    settle();
    check("dbg_count5", 32'(bit_counter), 32'd5);
    send_data(1'b1, 24'h13579B, 5, SW, 7, 1'b0);
`endif

    repeat (20) @(posedge input_clk);
    #1;
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);
    check("final_overrun_count", 32'(ovr_seen), 32'd1);
    check("final_frame_error_count", 32'(ferr_seen), 32'd1);
    check("latency_checked", 32'(lat_en), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
